// File: rtl/reg_read_datapath.sv
// Register-read stage datapath: 4-port physical register file with write bypass,
// MIPS next-address calculator and branch-condition comparator.
module reg_read_datapath #(
    parameter  int NUM_PHYS_REGS = 64,
    localparam int SEL_W         = $clog2(NUM_PHYS_REGS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [SEL_W-1:0] RegSelect1,
    input  logic [SEL_W-1:0] RegSelect2,
    input  logic [SEL_W-1:0] RegSelect3,
    input  logic [SEL_W-1:0] RegSelect4,
    input  logic             WriteEnable1_IN,
    input  logic             WriteEnable2_IN,
    input  logic             WriteEnable3_IN,
    input  logic             WriteEnable4_IN,
    input  logic [31:0]      Data1_IN,
    input  logic [31:0]      Data2_IN,
    input  logic [31:0]      Data3_IN,
    input  logic [31:0]      Data4_IN,
    output logic [31:0]      Data1_OUT,
    output logic [31:0]      Data2_OUT,
    output logic [31:0]      Data3_OUT,
    output logic [31:0]      Data4_OUT,
    input  logic [31:0]      Instr_PC_Plus4,
    input  logic [31:0]      Instruction,
    input  logic             Jump,
    input  logic             JumpRegister,
    input  logic [31:0]      RegisterValue,
    input  logic [SEL_W-1:0] Register,
    input  logic [31:0]      OpA,
    input  logic [31:0]      OpB,
    output logic [31:0]      NextInstructionAddress,
    output logic             taken
);

    localparam int NPORTS = 4;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    logic [SEL_W-1:0] sel   [NPORTS];
    logic             we    [NPORTS];
    logic [31:0]      wdata [NPORTS];
    logic [31:0]      rdata [NPORTS];

    assign sel[0]   = RegSelect1;
    assign sel[1]   = RegSelect2;
    assign sel[2]   = RegSelect3;
    assign sel[3]   = RegSelect4;
    assign we[0]    = WriteEnable1_IN;
    assign we[1]    = WriteEnable2_IN;
    assign we[2]    = WriteEnable3_IN;
    assign we[3]    = WriteEnable4_IN;
    assign wdata[0] = Data1_IN;
    assign wdata[1] = Data2_IN;
    assign wdata[2] = Data3_IN;
    assign wdata[3] = Data4_IN;

    assign Data1_OUT = rdata[0];
    assign Data2_OUT = rdata[1];
    assign Data3_OUT = rdata[2];
    assign Data4_OUT = rdata[3];

    function automatic logic sel_valid(input logic [SEL_W-1:0] s);
        return 32'(s) < NUM_PHYS_REGS;
    endfunction

    logic [31:0] regs_q [NUM_PHYS_REGS];
    logic [31:0] regs_d [NUM_PHYS_REGS];

    // Ports are applied in ascending order so the highest-numbered writer wins.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NPORTS; p++) begin
            if (we[p] && sel_valid(sel[p])) begin
                regs_d[sel[p]] = wdata[p];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHYS_REGS; gi++) begin : g_reg
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end

        // Bypass is suppressed under reset since those writes never land.
        for (gi = 0; gi < NPORTS; gi++) begin : g_read
            logic [31:0] rd_val;
            always_comb begin
                rd_val = sel_valid(sel[gi]) ? regs_q[sel[gi]] : '0;
                if (!RESET) begin
                    for (int p = 0; p < NPORTS; p++) begin
                        if (we[p] && sel_valid(sel[p]) && (sel[p] == sel[gi])) begin
                            rd_val = wdata[p];
                        end
                    end
                end
            end
            assign rdata[gi] = rd_val;
        end
    endgenerate

    logic [31:0] branch_offset;
    logic [31:0] jump_target;

    assign branch_offset = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
    assign jump_target   = {Instr_PC_Plus4[31:28], Instruction[25:0], 2'b00};

    always_comb begin
        if (JumpRegister) begin
            NextInstructionAddress = RegisterValue;
        end else if (Jump) begin
            NextInstructionAddress = jump_target;
        end else begin
            NextInstructionAddress = Instr_PC_Plus4 + branch_offset;
        end
    end

    logic [5:0]         opcode;
    logic [4:0]         rt;
    logic signed [31:0] op_a_s;
    logic signed [31:0] op_b_s;

    assign opcode = Instruction[31:26];
    assign rt     = Instruction[20:16];
    assign op_a_s = OpA;
    assign op_b_s = OpB;

    always_comb begin
        taken = 1'b0;
        if (Jump) begin
            taken = 1'b1;
        end else begin
            case (opcode)
                OP_BEQ:  taken = (op_a_s == op_b_s);
                OP_BNE:  taken = (op_a_s != op_b_s);
                OP_BLEZ: taken = (op_a_s <= 0);
                OP_BGTZ: taken = (op_a_s > 0);
                OP_REGIMM: begin
                    case (rt)
                        RT_BLTZ, RT_BLTZAL: taken = (op_a_s < 0);
                        RT_BGEZ, RT_BGEZAL: taken = (op_a_s >= 0);
                        default:            taken = 1'b0;
                    endcase
                end
                default: taken = 1'b0;
            endcase
        end
    end

    // Register is a debug tag only; fold it into a sink so it has a load.
    logic debug_unused;
    assign debug_unused = ^Register;

endmodule

// File: tb/tb_reg_read_datapath.sv
// Directed scoreboard bench for reg_read_datapath: expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_reg_read_datapath;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [5:0]  RegSelect1, RegSelect2, RegSelect3, RegSelect4;
    logic        WriteEnable1_IN, WriteEnable2_IN, WriteEnable3_IN, WriteEnable4_IN;
    logic [31:0] Data1_IN, Data2_IN, Data3_IN, Data4_IN;
    logic [31:0] Data1_OUT, Data2_OUT, Data3_OUT, Data4_OUT;
    logic [31:0] Instr_PC_Plus4, Instruction, RegisterValue, OpA, OpB;
    logic        Jump, JumpRegister;
    logic [5:0]  Register;
    logic [31:0] NextInstructionAddress;
    logic        taken;

    always #5 CLK = ~CLK;

    reg_read_datapath #(.NUM_PHYS_REGS(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .RegSelect1(RegSelect1), .RegSelect2(RegSelect2),
        .RegSelect3(RegSelect3), .RegSelect4(RegSelect4),
        .WriteEnable1_IN(WriteEnable1_IN), .WriteEnable2_IN(WriteEnable2_IN),
        .WriteEnable3_IN(WriteEnable3_IN), .WriteEnable4_IN(WriteEnable4_IN),
        .Data1_IN(Data1_IN), .Data2_IN(Data2_IN), .Data3_IN(Data3_IN), .Data4_IN(Data4_IN),
        .Data1_OUT(Data1_OUT), .Data2_OUT(Data2_OUT), .Data3_OUT(Data3_OUT), .Data4_OUT(Data4_OUT),
        .Instr_PC_Plus4(Instr_PC_Plus4), .Instruction(Instruction),
        .Jump(Jump), .JumpRegister(JumpRegister), .RegisterValue(RegisterValue),
        .Register(Register), .OpA(OpA), .OpB(OpB),
        .NextInstructionAddress(NextInstructionAddress), .taken(taken)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [64];

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
            $display("check %-14s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic no_writes();
        WriteEnable1_IN = 1'b0; WriteEnable2_IN = 1'b0;
        WriteEnable3_IN = 1'b0; WriteEnable4_IN = 1'b0;
    endtask

    function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] rt,
                                             input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    // Compare-unit step: drive one branch case and check taken against the required value.
    task automatic cmp_case(input string tag, input logic [31:0] instr, input logic jmp,
                            input logic [31:0] a, input logic [31:0] b, input logic exp);
        Instruction = instr;
        Jump        = jmp;
        OpA         = a;
        OpB         = b;
        expect_val(tag, {31'd0, exp});
        #1;
        chk({31'd0, taken});
    endtask

    task automatic nia_case(input string tag, input logic [31:0] pc4, input logic [31:0] instr,
                            input logic jmp, input logic jr, input logic [31:0] rv,
                            input logic [31:0] exp);
        Instr_PC_Plus4 = pc4;
        Instruction    = instr;
        Jump           = jmp;
        JumpRegister   = jr;
        RegisterValue  = rv;
        expect_val(tag, exp);
        #1;
        chk(NextInstructionAddress);
    endtask

    initial begin
        RESET = 1'b1;
        RegSelect1 = '0; RegSelect2 = '0; RegSelect3 = '0; RegSelect4 = '0;
        no_writes();
        Data1_IN = '0; Data2_IN = '0; Data3_IN = '0; Data4_IN = '0;
        Instr_PC_Plus4 = '0; Instruction = '0; Jump = 1'b0; JumpRegister = 1'b0;
        RegisterValue = '0; Register = '0; OpA = '0; OpB = '0;
        repeat (2) tick();
        RESET = 1'b0;

        // Populate registers, confirm they hold, then reset with writes still active.
        RegSelect1 = 6'd1; RegSelect2 = 6'd2; RegSelect3 = 6'd3; RegSelect4 = 6'd4;
        Data1_IN = 32'h1111_0001; Data2_IN = 32'h2222_0002;
        Data3_IN = 32'h3333_0003; Data4_IN = 32'h4444_0004;
        WriteEnable1_IN = 1'b1; WriteEnable2_IN = 1'b1;
        WriteEnable3_IN = 1'b1; WriteEnable4_IN = 1'b1;
        tick();
        no_writes();
        expect_val("pre_rst_r1", 32'h1111_0001);
        expect_val("pre_rst_r4", 32'h4444_0004);
        #1;
        chk(Data1_OUT);
        chk(Data4_OUT);

        RegSelect1 = 6'd60; RegSelect2 = 6'd61; RegSelect3 = 6'd62; RegSelect4 = 6'd63;
        WriteEnable1_IN = 1'b1; WriteEnable2_IN = 1'b1;
        WriteEnable3_IN = 1'b1; WriteEnable4_IN = 1'b1;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        no_writes();
        for (int s = 0; s < 64; s += 4) begin
            RegSelect1 = 6'(s); RegSelect2 = 6'(s + 1);
            RegSelect3 = 6'(s + 2); RegSelect4 = 6'(s + 3);
            expect_val($sformatf("rst_r%0d", s), 32'd0);
            expect_val($sformatf("rst_r%0d", s + 1), 32'd0);
            expect_val($sformatf("rst_r%0d", s + 2), 32'd0);
            expect_val($sformatf("rst_r%0d", s + 3), 32'd0);
            #1;
            chk(Data1_OUT); chk(Data2_OUT); chk(Data3_OUT); chk(Data4_OUT);
        end
        foreach (mdl[i]) mdl[i] = 32'd0;

        // Write through port 4, bypass on port 2 in the same cycle.
        RegSelect4 = 6'd5; Data4_IN = 32'hDEAD_BEEF; WriteEnable4_IN = 1'b1;
        RegSelect2 = 6'd5; RegSelect1 = 6'd6;
        expect_val("bypass_p2", 32'hDEAD_BEEF);
        expect_val("no_bypass_p1", 32'd0);
        #1;
        chk(Data2_OUT);
        chk(Data1_OUT);
        tick();
        no_writes();
        RegSelect1 = 6'd5;
        expect_val("readback_p1", 32'hDEAD_BEEF);
        #1;
        chk(Data1_OUT);
        mdl[5] = 32'hDEAD_BEEF;

        // Port 3 and 4 collide on reg 7; ports 1 and 2 collide on reg 9.
        RegSelect3 = 6'd7; Data3_IN = 32'h11; WriteEnable3_IN = 1'b1;
        RegSelect4 = 6'd7; Data4_IN = 32'h22; WriteEnable4_IN = 1'b1;
        RegSelect1 = 6'd9; Data1_IN = 32'h0A; WriteEnable1_IN = 1'b1;
        RegSelect2 = 6'd9; Data2_IN = 32'h0B; WriteEnable2_IN = 1'b1;
        expect_val("conflict_byp3", 32'h22);
        expect_val("conflict_byp1", 32'h0B);
        #1;
        chk(Data3_OUT);
        chk(Data1_OUT);
        tick();
        no_writes();
        RegSelect1 = 6'd7; RegSelect2 = 6'd9;
        expect_val("conflict_r7", 32'h22);
        expect_val("conflict_r9", 32'h0B);
        #1;
        chk(Data1_OUT);
        chk(Data2_OUT);
        mdl[7] = 32'h22;
        mdl[9] = 32'h0B;

        // Register 0 is an ordinary register.
        RegSelect1 = 6'd0; Data1_IN = 32'h55; WriteEnable1_IN = 1'b1;
        tick();
        no_writes();
        RegSelect4 = 6'd0;
        expect_val("r0_writable", 32'h55);
        #1;
        chk(Data4_OUT);
        mdl[0] = 32'h55;

        // Four independent writes per cycle over regs 16..47.
        for (int it = 0; it < 8; it++) begin
            RegSelect1 = 6'(16 + it * 4); RegSelect2 = 6'(17 + it * 4);
            RegSelect3 = 6'(18 + it * 4); RegSelect4 = 6'(19 + it * 4);
            Data1_IN = $urandom; Data2_IN = $urandom; Data3_IN = $urandom; Data4_IN = $urandom;
            WriteEnable1_IN = 1'b1; WriteEnable2_IN = 1'b1;
            WriteEnable3_IN = 1'b1; WriteEnable4_IN = (it % 2) == 0;
            mdl[16 + it * 4] = Data1_IN;
            mdl[17 + it * 4] = Data2_IN;
            mdl[18 + it * 4] = Data3_IN;
            if ((it % 2) == 0) mdl[19 + it * 4] = Data4_IN;
            tick();
        end
        no_writes();
        for (int s = 16; s < 48; s += 2) begin
            RegSelect2 = 6'(s); RegSelect3 = 6'(s + 1);
            expect_val($sformatf("multi_r%0d", s), mdl[s]);
            expect_val($sformatf("multi_r%0d", s + 1), mdl[s + 1]);
            #1;
            chk(Data2_OUT);
            chk(Data3_OUT);
        end

        // Next-address calculator.
        nia_case("nia_branch_neg", 32'h0040_0010, mk_instr(6'b000100, 5'd0, 16'hFFFE), 1'b0, 1'b0,
                 32'h0, 32'h0040_0008);
        nia_case("nia_branch_pos", 32'h0040_0010, mk_instr(6'b000100, 5'd0, 16'h0004), 1'b0, 1'b0,
                 32'h0, 32'h0040_0020);
        nia_case("nia_wrap", 32'hFFFF_FFFC, mk_instr(6'b000101, 5'd0, 16'h0001), 1'b0, 1'b0,
                 32'h0, 32'h0000_0000);
        nia_case("nia_jump", 32'h0000_0010, {6'b000010, 26'h010_0000}, 1'b1, 1'b0,
                 32'h0, 32'h0040_0000);
        nia_case("nia_jump_hi", 32'hA000_0004, {6'b000011, 26'h000_0003}, 1'b1, 1'b0,
                 32'h0, 32'hA000_000C);
        nia_case("nia_jr", 32'h0040_0010, {6'b000010, 26'h010_0000}, 1'b1, 1'b1,
                 32'h0000_1234, 32'h0000_1234);
        JumpRegister = 1'b0;

        // Branch comparator.
        cmp_case("beq_eq", mk_instr(6'b000100, 5'd0, 16'h0), 1'b0, 32'd5, 32'd5, 1'b1);
        cmp_case("beq_ne", mk_instr(6'b000100, 5'd0, 16'h0), 1'b0, 32'd5, 32'd6, 1'b0);
        cmp_case("bne_eq", mk_instr(6'b000101, 5'd0, 16'h0), 1'b0, 32'd5, 32'd5, 1'b0);
        cmp_case("bne_ne", mk_instr(6'b000101, 5'd0, 16'h0), 1'b0, 32'd5, 32'd7, 1'b1);
        cmp_case("blez_zero", mk_instr(6'b000110, 5'd0, 16'h0), 1'b0, 32'd0, 32'd9, 1'b1);
        cmp_case("blez_pos", mk_instr(6'b000110, 5'd0, 16'h0), 1'b0, 32'd1, 32'd0, 1'b0);
        cmp_case("bgtz_neg", mk_instr(6'b000111, 5'd0, 16'h0), 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        cmp_case("bgtz_pos", mk_instr(6'b000111, 5'd0, 16'h0), 1'b0, 32'd1, 32'd0, 1'b1);
        cmp_case("bltz_min", mk_instr(6'b000001, 5'b00000, 16'h0), 1'b0, 32'h8000_0000, 32'd0, 1'b1);
        cmp_case("bltzal_zero", mk_instr(6'b000001, 5'b10000, 16'h0), 1'b0, 32'd0, 32'd0, 1'b0);
        cmp_case("bgez_zero", mk_instr(6'b000001, 5'b00001, 16'h0), 1'b0, 32'd0, 32'd0, 1'b1);
        cmp_case("bgezal_neg", mk_instr(6'b000001, 5'b10001, 16'h0), 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0);
        cmp_case("regimm_other", mk_instr(6'b000001, 5'b00010, 16'h0), 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0);
        cmp_case("jump_taken", mk_instr(6'b000010, 5'd0, 16'h0), 1'b1, 32'd1, 32'd2, 1'b1);
        cmp_case("addi_never", mk_instr(6'b001000, 5'd0, 16'h0), 1'b0, 32'd5, 32'd5, 1'b0);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
